swervolf_gpio: RTL and testbench

SWERVOLF_GPIO -- requirements
Module: swervolf_gpio

---
 rtl/swervolf_gpio_if.sv | 20 ++
 rtl/swervolf_gpio.sv | 168 ++++++++++++++++
 tb/tb_swervolf_gpio.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/swervolf_gpio_if.sv
// Wishbone-style register bus between a master and the GPIO block.
interface swervolf_gpio_if;
    logic [2:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/swervolf_gpio.sv
// GPIO block: synchronised and debounced inputs with edge-selectable
// pending interrupts, registered outputs, and a small register file
// behind a single-cycle-ack bus.
module swervolf_gpio #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    swervolf_gpio_if.slave   wb,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic             o_irq
);

    // DB_CYCLES of 0 and 1 both mean "accept on the first mismatching sample"
    localparam int unsigned DB_EFF   = (DB_CYCLES > 1) ? DB_CYCLES : 1;
    localparam int unsigned CNT_W    = $clog2((DB_CYCLES > 2) ? DB_CYCLES : 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_EFF - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] stable_q;
    logic [CNT_W-1:0] db_cnt [WIDTH];
    logic [WIDTH-1:0] mism;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] set_evt;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] irq_pend_q;
    logic [WIDTH-1:0] edge_sel_q;
    logic [WIDTH-1:0] both_q;
    logic             irq_q;

    logic             bus_acc;
    logic             bus_wr;
    logic [WIDTH-1:0] wr_dat;
    logic [WIDTH-1:0] pend_clr;
    logic [31:0]      rd_data;
    logic             unused_dat;

    assign sync_val   = sync_q[SYNC_STAGES-1];
    assign o_gpio     = out_q;
    assign o_irq      = irq_q;
    assign unused_dat = ^wb.i_wb_dat;

    // A new access starts only when the previous cycle did not ack,
    // which keeps ack from ever lasting two clocks.
    assign bus_acc = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack;
    assign bus_wr  = bus_acc & wb.i_wb_we;
    assign wr_dat  = wb.i_wb_dat[WIDTH-1:0];

    // Metastability chain for the asynchronous pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_gpio;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Per-channel acceptance and edge event decode
    always_comb begin
        mism    = sync_val ^ stable_q;
        flip    = '0;
        set_evt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            flip[i] = mism[i] && (db_cnt[i] == CNT_LAST);
        end
        // sync ^ edge_sel is 1 for a rise with sel=0 or a fall with sel=1
        set_evt = flip & (both_q | (sync_val ^ edge_sel_q));
    end

    // Debounce counters and stable state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (!mism[i] || flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
                if (flip[i]) begin
                    stable_q[i] <= sync_val[i];
                end
            end
        end
    end

    // Register read mux, zero-extended to the bus width
    always_comb begin
        rd_data = '0;
        case (wb.i_wb_adr)
            3'd0:    rd_data = 32'(stable_q);
            3'd1:    rd_data = 32'(out_q);
            3'd2:    rd_data = 32'(irq_en_q);
            3'd3:    rd_data = 32'(irq_pend_q);
            3'd4:    rd_data = 32'(edge_sel_q);
            3'd5:    rd_data = 32'(both_q);
            default: rd_data = '0;
        endcase
    end

    // Write-one-to-clear mask for the pending register
    always_comb begin
        pend_clr = '0;
        if (bus_wr && (wb.i_wb_adr == 3'd3)) begin
            pend_clr = wr_dat;
        end
    end

    // Control registers; pending sets win over a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            irq_en_q   <= '0;
            irq_pend_q <= '0;
            edge_sel_q <= '0;
            both_q     <= '0;
        end else begin
            if (bus_wr) begin
                case (wb.i_wb_adr)
                    3'd1:    out_q      <= wr_dat;
                    3'd2:    irq_en_q   <= wr_dat;
                    3'd4:    edge_sel_q <= wr_dat;
                    3'd5:    both_q     <= wr_dat;
                    default: ;
                endcase
            end
            irq_pend_q <= (irq_pend_q & ~pend_clr) | set_evt;
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(irq_pend_q & irq_en_q);
        end
    end

    // Bus acknowledge and read data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.o_wb_ack <= 1'b0;
            wb.o_wb_rdt <= '0;
        end else begin
            wb.o_wb_ack <= bus_acc;
            if (bus_acc) begin
                wb.o_wb_rdt <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_swervolf_gpio.sv
// Self-checking bench for swervolf_gpio: directed scenarios plus random
// pin/bus traffic compared against a window-based behavioural model.
module tb_swervolf_gpio;

    localparam int unsigned W    = 16;
    localparam int unsigned SS   = 2;
    localparam int unsigned DB   = 4;
    localparam int unsigned NWIN = (DB > 1) ? DB : 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] i_gpio = '0;
    logic [W-1:0] o_gpio;
    logic         o_irq;

    swervolf_gpio_if wb ();

    swervolf_gpio #(
        .WIDTH      (W),
        .SYNC_STAGES(SS),
        .DB_CYCLES  (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb),
        .i_gpio(i_gpio),
        .o_gpio(o_gpio),
        .o_irq (o_irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_pipe [SS];
    logic [W-1:0] m_win  [NWIN];
    logic [W-1:0] m_stable, m_out, m_en, m_pend, m_esel, m_both;
    logic         m_ack, m_irq;
    logic [31:0]  m_rdt;

    function automatic logic [31:0] m_read(input logic [2:0] adr);
        case (adr)
            3'd0:    return {16'h0, m_stable};
            3'd1:    return {16'h0, m_out};
            3'd2:    return {16'h0, m_en};
            3'd3:    return {16'h0, m_pend};
            3'd4:    return {16'h0, m_esel};
            3'd5:    return {16'h0, m_both};
            default: return 32'h0;
        endcase
    endfunction

    // Stable flips once the last NWIN synchronised samples all disagree with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) m_pipe[i] <= '0;
            for (int i = 0; i < NWIN; i++) m_win[i] <= '0;
            m_stable <= '0; m_out <= '0; m_en <= '0; m_pend <= '0;
            m_esel <= '0; m_both <= '0; m_ack <= 1'b0; m_irq <= 1'b0; m_rdt <= '0;
        end else begin
            logic [W-1:0] sync, chg, nst, rise, fall, setm, clr;
            sync = m_pipe[SS-1];
            chg  = sync ^ m_stable;
            for (int j = 0; j < NWIN - 1; j++) chg = chg & (m_win[j] ^ m_stable);
            nst  = m_stable ^ chg;
            rise = chg & nst;
            fall = chg & ~nst;
            setm = (m_both & chg) | (~m_both & ~m_esel & rise) | (~m_both & m_esel & fall);
            clr  = '0;
            if (wb.i_wb_cyc && wb.i_wb_stb && !m_ack) begin
                m_ack <= 1'b1;
                m_rdt <= m_read(wb.i_wb_adr);
                if (wb.i_wb_we) begin
                    case (wb.i_wb_adr)
                        3'd1: m_out  <= wb.i_wb_dat[15:0];
                        3'd2: m_en   <= wb.i_wb_dat[15:0];
                        3'd3: clr     = wb.i_wb_dat[15:0];
                        3'd4: m_esel <= wb.i_wb_dat[15:0];
                        3'd5: m_both <= wb.i_wb_dat[15:0];
                        default: ;
                    endcase
                end
            end else begin
                m_ack <= 1'b0;
            end
            m_pend   <= (m_pend & ~clr) | setm;
            m_irq    <= |(m_pend & m_en);
            m_stable <= nst;
            m_win[0] <= sync;
            for (int j = 1; j < NWIN; j++) m_win[j] <= m_win[j-1];
            m_pipe[0] <= i_gpio;
            for (int j = 1; j < SS; j++) m_pipe[j] <= m_pipe[j-1];
        end
    end

    // Continuous comparison of outputs against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("gpio", 32'(o_gpio), 32'(m_out));
            check("irq",  32'(o_irq),  32'(m_irq));
            check("ack",  32'(wb.o_wb_ack), 32'(m_ack));
            if (m_ack) check("rdt", wb.o_wb_rdt, m_rdt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_op(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                          output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = we;
        wb.i_wb_adr = adr;  wb.i_wb_dat = dat;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wb.o_wb_ack) begin
                got = 1'b1;
                rd  = wb.o_wb_rdt;
                break;
            end
        end
        wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
        if (!got) check("bus_timeout", 32'(got), 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
        wb.i_wb_adr = '0;   wb.i_wb_dat = '0;
        repeat (3) @(negedge clk);
        check("rst_gpio", 32'(o_gpio), 32'h0);
        check("rst_irq",  32'(o_irq),  32'h0);
        check("rst_ack",  32'(wb.o_wb_ack), 32'h0);
        check("rst_rdt",  wb.o_wb_rdt, 32'h0);
        rst_n = 1'b1;

        // Pin 3 rising: stable and pend on edge 6, irq on edge 7
        bus_op(1'b1, 3'd2, 32'h8, rd);
        i_gpio[3] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) check("irq_edge6", 32'(o_irq), 32'h0);
            if (k == 7) check("irq_edge7", 32'(o_irq), 32'h1);
        end
        bus_op(1'b0, 3'd0, 32'h0, rd); check("in_pin3", rd, 32'h8);
        bus_op(1'b0, 3'd3, 32'h0, rd); check("pend_pin3", rd, 32'h8);

        // Short glitch is rejected
        bus_op(1'b1, 3'd3, 32'hFFFF, rd);
        i_gpio[0] = 1'b1; idle(3); i_gpio[0] = 1'b0; idle(10);
        bus_op(1'b0, 3'd0, 32'h0, rd); check("glitch_in", rd, 32'h8);
        bus_op(1'b0, 3'd3, 32'h0, rd); check("glitch_pend", rd, 32'h0);

        // Falling-edge select, then both edges
        bus_op(1'b1, 3'd4, 32'h1, rd);
        i_gpio[0] = 1'b1; idle(10);
        bus_op(1'b0, 3'd3, 32'h0, rd); check("fall_on_rise", rd, 32'h0);
        i_gpio[0] = 1'b0; idle(10);
        bus_op(1'b0, 3'd3, 32'h0, rd); check("fall_on_fall", rd, 32'h1);
        bus_op(1'b1, 3'd3, 32'h1, rd);
        bus_op(1'b1, 3'd5, 32'h1, rd);
        i_gpio[0] = 1'b1; idle(10);
        bus_op(1'b0, 3'd3, 32'h0, rd); check("both_rise", rd, 32'h1);
        bus_op(1'b1, 3'd3, 32'h1, rd);
        bus_op(1'b0, 3'd3, 32'h0, rd); check("pend_cleared", rd, 32'h0);
        i_gpio[0] = 1'b0; idle(10);
        bus_op(1'b0, 3'd3, 32'h0, rd); check("both_fall", rd, 32'h1);
        bus_op(1'b1, 3'd3, 32'h1, rd);

        // Output register and unmapped indices
        bus_op(1'b1, 3'd1, 32'hFFFF_A5A5, rd);
        check("gpio_a5a5", 32'(o_gpio), 32'hA5A5);
        bus_op(1'b0, 3'd1, 32'h0, rd); check("rd_out", rd, 32'h0000_A5A5);
        bus_op(1'b1, 3'd6, 32'hFFFF_FFFF, rd);
        bus_op(1'b0, 3'd6, 32'h0, rd); check("rd_idx6", rd, 32'h0);
        bus_op(1'b0, 3'd7, 32'h0, rd); check("rd_idx7", rd, 32'h0);

        // Reset mid-debounce and mid-write, between clock edges
        i_gpio[5] = 1'b1; idle(3);
        wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b1;
        wb.i_wb_adr = 3'd1; wb.i_wb_dat = 32'h1234;
        #2 rst_n = 1'b0;
        #1;
        check("arst_gpio", 32'(o_gpio), 32'h0);
        check("arst_irq",  32'(o_irq),  32'h0);
        check("arst_ack",  32'(wb.o_wb_ack), 32'h0);
        check("arst_rdt",  wb.o_wb_rdt, 32'h0);
        @(negedge clk);
        wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_ack_after_rst", 32'(wb.o_wb_ack), 32'h0);
        end
        bus_op(1'b0, 3'd1, 32'h0, rd); check("out_after_rst", rd, 32'h0);

        // Random pin and bus traffic against the model
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    i_gpio = 16'($urandom);
                    idle(int'($urandom_range(1, 12)));
                end
                1: begin
                    i_gpio[$urandom_range(0, W-1)] ^= 1'b1;
                    idle(int'($urandom_range(1, 6)));
                end
                default: begin
                    bus_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, rd);
                end
            endcase
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
